// File: rtl/hex_display_capture.sv
// ---------------------------------------------------------------------------
// hex_display_capture
//
// Passive reader for the multiplexed 4-digit hex display bus. It watches the
// active-low segment/grid lines and waits for each digit dwell to settle. It
// then decodes the 7-segment pattern back to a nibble and assembles a full
// 16-bit display word once all four digits have been captured. It never
// drives the display bus.
//
// Parameters:
//   STABLE_CYCLES  - consecutive identical registered samples before a digit
//                    is captured (min 2)
//   TIMEOUT_CYCLES - cycles without a completed frame before stale asserts
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset       in   asynchronous active-low reset
//   hex_seg     in   [7:0] active-low segments {dp,g,f,e,d,c,b,a}
//   hex_grid    in   [3:0] active-low one-hot digit enable, bit0 = rightmost
//   value       out  [15:0] last completed frame {d3,d2,d1,d0}
//   dp          out  [3:0] decimal point per digit from last frame (1 = lit)
//   digit_err   out  [3:0] per digit: last captured pattern did not decode
//   frame_valid out  one-cycle pulse when value/dp/digit_err update
//   stale       out  high when no frame completed within TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module hex_display_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  hex_seg,
    input  logic [3:0]  hex_grid,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        stale
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tcnt;

    logic [7:0]    seg_q;
    logic [3:0]    grid_q;
    logic [11:0]   prev_q;

    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic [3:0]    shadow_err;
    logic [3:0]    mask;

    logic          grid_valid;
    logic          same;
    logic          capture;
    logic          complete;
    logic [3:0]    dig_sel;
    logic          dec_ok;
    logic [3:0]    dec_nib;

    // Active-high a..g pattern to {match, nibble}.
    function automatic logic [4:0] decode7(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    assign dig_sel           = ~grid_q;
    assign grid_valid        = $onehot(dig_sel);
    assign same              = ({seg_q, grid_q} == prev_q);
    assign {dec_ok, dec_nib} = decode7(~seg_q[6:0]);
    assign complete          = (mask == 4'hF);

    // Input registers plus the previous registered sample for change detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            seg_q  <= '1;
            grid_q <= '1;
            prev_q <= '1;
        end else begin
            seg_q  <= hex_seg;
            grid_q <= hex_grid;
            prev_q <= {seg_q, grid_q};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The capture fires on the sample that makes STABLE_CYCLES identical
    // samples, so cnt only needs to reach STABLE_CYCLES-1 beforehand.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (grid_valid) begin
                    state_n = S_DWELL;
                    cnt_n   = CW'(1);
                end
            end
            S_DWELL: begin
                if (!same) begin
                    state_n = grid_valid ? S_DWELL : S_IDLE;
                    cnt_n   = grid_valid ? CW'(1) : '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (!same) begin
                    state_n = grid_valid ? S_DWELL : S_IDLE;
                    cnt_n   = grid_valid ? CW'(1) : '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Shadow frame and capture mask. A capture coinciding with completion
    // seeds the next frame's mask; value picks up the pre-capture shadow.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            shadow_err <= '0;
            mask       <= '0;
        end else begin
            if (capture) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (dig_sel[i]) begin
                        if (dec_ok)
                            shadow_val[4*i +: 4] <= dec_nib;
                        shadow_err[i] <= ~dec_ok;
                        shadow_dp[i]  <= ~seg_q[7];
                    end
                end
            end
            if (complete)
                mask <= capture ? dig_sel : '0;
            else if (capture)
                mask <= mask | dig_sel;
        end
    end

    // Published frame, pulse and staleness tracking.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            value       <= '0;
            dp          <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            stale       <= 1'b1;
            tcnt        <= '0;
        end else begin
            frame_valid <= complete;
            if (complete) begin
                value     <= shadow_val;
                dp        <= shadow_dp;
                digit_err <= shadow_err;
                stale     <= 1'b0;
                tcnt      <= '0;
            end else begin
                if (tcnt != TW'(TIMEOUT_CYCLES))
                    tcnt <= tcnt + TW'(1);
                if (tcnt >= TW'(TIMEOUT_CYCLES - 1))
                    stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_capture.sv
module tb_hex_display_capture;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  hex_seg;
    logic [3:0]  hex_grid;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  e;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned fv_count    = 0;
    int unsigned cyc         = 0;
    int unsigned last_fv_cyc = 0;

    hex_display_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .hex_seg    (hex_seg),
        .hex_grid   (hex_grid),
        .value      (value),
        .dp         (dp),
        .digit_err  (digit_err),
        .frame_valid(frame_valid),
        .stale      (stale)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every frame_valid pulse must match the oldest
    // expected frame.
    always @(negedge Clk) begin
        if (Reset === 1'b1 && frame_valid === 1'b1) begin
            frame_t f;
            fv_count++;
            last_fv_cyc = cyc;
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                f = exp_q.pop_front();
                check("frame_value", 32'(value), 32'(f.v));
                check("frame_dp", 32'(dp), 32'(f.d));
                check("frame_err", 32'(digit_err), 32'(f.e));
                check("frame_stale", 32'(stale), 32'd0);
            end
        end
    end

    task automatic drive(input logic [7:0] s, input logic [3:0] g, input int unsigned n);
        hex_seg  = s;
        hex_grid = g;
        repeat (n) @(negedge Clk);
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3,
                        input int unsigned n, input bit expect_frame,
                        input logic [15:0] ev, input logic [3:0] ed,
                        input logic [3:0] ee);
        frame_t f;
        if (expect_frame) begin
            f.v = ev;
            f.d = ed;
            f.e = ee;
            exp_q.push_back(f);
        end
        drive(s0, 4'b1110, n);
        drive(s1, 4'b1101, n);
        drive(s2, 4'b1011, n);
        drive(s3, 4'b0111, n);
        drive(8'hFF, 4'hF, 4);
    endtask

    initial begin
        int unsigned base;
        Reset    = 1'b0;
        hex_seg  = 8'hFF;
        hex_grid = 4'hF;
        repeat (3) @(negedge Clk);
        check("rst_value", 32'(value), 32'd0);
        check("rst_dp", 32'(dp), 32'd0);
        check("rst_err", 32'(digit_err), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_stale", 32'(stale), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);

        // Dwell too short for STABLE_CYCLES=4: nothing captured.
        scan(8'h83, 8'hF9, 8'h88, 8'h82, 3, 1'b0, '0, '0, '0);
        check("short_fv_count", fv_count, 0);
        check("short_value", 32'(value), 32'd0);
        check("short_stale", 32'(stale), 32'd1);

        // Blank d2 keeps its (reset) nibble and flags an error.
        scan(8'h83, 8'hF9, 8'hFF, 8'h82, 8, 1'b1, 16'h601B, 4'b0000, 4'b0100);
        check("blank_drained", exp_q.size(), 0);

        // Normal frame.
        scan(8'h83, 8'hF9, 8'h88, 8'h82, 8, 1'b1, 16'h6A1B, 4'b0000, 4'b0000);
        check("full_drained", exp_q.size(), 0);
        check("full_fv_count", fv_count, 2);

        // Decimal point lit on d0 (0 with dp = 8'h40).
        scan(8'h40, 8'hC0, 8'hC0, 8'hC0, 8, 1'b1, 16'h0000, 4'b0001, 4'b0000);
        check("dp_drained", exp_q.size(), 0);

        // Two grid lines low: invalid, no captures.
        base = fv_count;
        drive(8'hC0, 4'b1100, 20);
        check("twolow_fv", fv_count - base, 0);
        check("twolow_value", 32'(value), 32'd0);
        scan(8'h99, 8'hB0, 8'hA4, 8'hF9, 8, 1'b1, 16'h1234, 4'b0000, 4'b0000);
        check("after_twolow_drained", exp_q.size(), 0);

        // Reset mid-frame discards captured digits.
        drive(8'hC0, 4'b1110, 8);
        drive(8'hF9, 4'b1101, 8);
        Reset = 1'b0;
        #1;
        check("midrst_value", 32'(value), 32'd0);
        check("midrst_stale", 32'(stale), 32'd1);
        hex_grid = 4'hF;
        hex_seg  = 8'hFF;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        base = fv_count;
        drive(8'h88, 4'b1011, 8);
        drive(8'h82, 4'b0111, 8);
        drive(8'hFF, 4'hF, 4);
        check("partial_no_frame", fv_count - base, 0);
        check("partial_value", 32'(value), 32'd0);
        scan(8'h83, 8'hF9, 8'h88, 8'h82, 8, 1'b1, 16'h6A1B, 4'b0000, 4'b0000);
        check("postrst_one_frame", fv_count - base, 1);
        check("postrst_drained", exp_q.size(), 0);

        // Timeout: stale rises exactly 64 cycles after the completing edge.
        while (cyc < last_fv_cyc + 63) @(negedge Clk);
        check("stale_before_timeout", 32'(stale), 32'd0);
        @(negedge Clk);
        check("stale_at_timeout", 32'(stale), 32'd1);
        repeat (5) @(negedge Clk);
        check("stale_holds", 32'(stale), 32'd1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
